config_params_cast_sequencer: RTL and testbench
===============================================

// Module: config_params_cast_sequencer
// PURPOSE
//  Second-generation parameter-cast sequencer for engine config paths. Matches engine response
//  triggers (bundle/lane id) against MASK_WIDTH per-slot config entries and emits the matching
//  slots' param fields serially, lowest slot first, one per output handshake. Adds trigger
//  queueing, ready/valid backpressure, and a guarded config load with drop statistics.
// PARAMETERS
//  MASK_WIDTH  8   number of param slots (>=2)
//  FIELD_W     64  width of one param field
//  ID_W        8   width of bundle id and lane id
//  TRIG_DEPTH  4   pending-trigger FIFO depth (power of 2, >=2)
//  FIRST_ONLY  0   1: emit only lowest matching slot per trigger; 0: emit all matches
//  SLOT_W = max(1,$clog2(MASK_WIDTH)), CNT_W = $clog2(TRIG_DEPTH)+1 (derived)
// PORTS
//  ap_clk          in   1                   clock
//  areset          in   1                   synchronous reset, active-high
//  cfg_load        in   1                   load config inputs (honoured only when cfg_ready)
//  cfg_ready       out  1                   1 = FIFO empty and emitter IDLE
//  cfg_cast_mask   in   MASK_WIDTH          per-slot cast enable
//  cfg_lane_mask   in   MASK_WIDTH          per-slot lane enable
//  cfg_bundle_id   in   MASK_WIDTH*ID_W     per-slot expected bundle id (slot i = bits [i*ID_W +: ID_W])
//  cfg_lane_id     in   MASK_WIDTH*ID_W     per-slot expected lane id
//  cfg_param_field in   MASK_WIDTH*FIELD_W  per-slot param field
//  trig_valid      in   1                   engine response trigger valid
//  trig_ready      out  1                   FIFO not full
//  trig_bundle_id  in   ID_W                source bundle id of trigger
//  trig_lane_id    in   ID_W                source lane id of trigger
//  out_valid       out  1                   emitted slot valid
//  out_ready       in   1                   downstream accept
//  out_param_field out  FIELD_W             param field of emitted slot
//  out_slot_idx    out  SLOT_W              index of emitted slot
//  out_last        out  1                   final beat for this trigger
//  out_kernel_valid out MASK_WIDTH          thermometer: bits [MASK_WIDTH-1:out_slot_idx] = 1
//  pending_count   out  CNT_W               FIFO occupancy
//  drop_count      out  16                  zero-match triggers, saturating at 16'hFFFF
// BEHAVIOUR
//  - Reset (any cycle, incl. mid-emission): FIFO flushed, emitter IDLE, all config regs 0,
//    out_valid=0, out_* data=0, pending_count=0, drop_count=0, cfg_ready=1, trig_ready=1.
//  - Config: cfg_load & cfg_ready latches all cfg_* into regs at the edge; cfg_load while
//    !cfg_ready is ignored (no partial update). Matching always uses latched regs.
//  - Accept = trig_valid & trig_ready. Match mask M[i] = (cast[i]|lane[i]) &
//    (trig_bundle_id==bundle_id[i]) & (trig_lane_id==lane_id[i]).
//    FIRST_ONLY=1 reduces M to its lowest set bit.
//  - M!=0: push M into FIFO. M==0: not pushed; drop_count += 1 (saturate).
//  - trig_ready = (pending_count < TRIG_DEPTH). No same-cycle pass-through when full.
//  - FSM IDLE: if FIFO non-empty, pop head into emit mask E; go EMIT.
//  - FSM EMIT: slot = lowest set bit of E; out_valid=1, out_last = (E has one bit set).
//    On out_valid & out_ready: clear that bit.
//    - Not last: stay EMIT.
//    - Last, FIFO non-empty: pop the next mask same cycle (no bubble).
//    - Last, FIFO empty: go IDLE.
//  - Outputs are registered and stable while out_valid & !out_ready (AXI-style hold).
//  - Latency: trigger accepted at cycle T into empty block -> out_valid at T+2.
//    Throughput: 1 slot/cycle under continuous out_ready.
//  - Push and pop in the same cycle: pending_count unchanged; FIFO wraps modulo TRIG_DEPTH.
//  - pending_count counts FIFO entries only, not the mask held in the emitter.
// TESTING
//  1 cast=8'h0B, all ids match 3/1, trig(3,1), out_ready=1 -> slots 0,1,3 on T+2..T+4;
//    out_last only on slot 3; kernel_valid FF,FE,F8.
//  2 FIRST_ONLY=1, same config and trigger -> single beat, slot 0, out_last=1.
//  3 out_ready=0 for 5 cycles mid-burst -> field/idx held constant; no slot lost or duplicated.
//  4 6 back-to-back triggers, out_ready=0 -> trig_ready low after 4 accepted plus 1 in emitter;
//    pending_count=4; drain yields in-order beats, no bubble between triggers.
//  5 trig id mismatching all slots x3 -> drop_count=3, no out_valid; at 16'hFFFF stays FFFF.
//  6 areset during emission of slot 1 of 3 -> next cycle out_valid=0, counts 0;
//    cfg_load while busy leaves old config active.

Source files
------------

// File: rtl/config_params_cast_sequencer_if.sv
// Config, trigger and emitted-slot signals of the parameter-cast sequencer.
// The slave modport is the sequencer's view; master is the driving side.
interface config_params_cast_sequencer_if #(
  parameter int unsigned MASK_WIDTH = 8,
  parameter int unsigned FIELD_W    = 64,
  parameter int unsigned ID_W       = 8,
  parameter int unsigned TRIG_DEPTH = 4
);
  localparam int unsigned SLOT_W = (MASK_WIDTH > 1) ? $clog2(MASK_WIDTH) : 1;
  localparam int unsigned CNT_W  = $clog2(TRIG_DEPTH) + 1;

  logic                          cfg_load;
  logic                          cfg_ready;
  logic [MASK_WIDTH-1:0]         cfg_cast_mask;
  logic [MASK_WIDTH-1:0]         cfg_lane_mask;
  logic [MASK_WIDTH*ID_W-1:0]    cfg_bundle_id;
  logic [MASK_WIDTH*ID_W-1:0]    cfg_lane_id;
  logic [MASK_WIDTH*FIELD_W-1:0] cfg_param_field;
  logic                          trig_valid;
  logic                          trig_ready;
  logic [ID_W-1:0]               trig_bundle_id;
  logic [ID_W-1:0]               trig_lane_id;
  logic                          out_valid;
  logic                          out_ready;
  logic [FIELD_W-1:0]            out_param_field;
  logic [SLOT_W-1:0]             out_slot_idx;
  logic                          out_last;
  logic [MASK_WIDTH-1:0]         out_kernel_valid;
  logic [CNT_W-1:0]              pending_count;
  logic [15:0]                   drop_count;

  modport slave (
    input  cfg_load, cfg_cast_mask, cfg_lane_mask, cfg_bundle_id, cfg_lane_id, cfg_param_field,
    input  trig_valid, trig_bundle_id, trig_lane_id, out_ready,
    output cfg_ready, trig_ready, out_valid, out_param_field, out_slot_idx, out_last,
    output out_kernel_valid, pending_count, drop_count
  );

  modport master (
    output cfg_load, cfg_cast_mask, cfg_lane_mask, cfg_bundle_id, cfg_lane_id, cfg_param_field,
    output trig_valid, trig_bundle_id, trig_lane_id, out_ready,
    input  cfg_ready, trig_ready, out_valid, out_param_field, out_slot_idx, out_last,
    input  out_kernel_valid, pending_count, drop_count
  );
endinterface

// File: rtl/config_params_cast_sequencer.sv
// Matches engine triggers against per-slot config, queues match masks, and emits the
// matching slots' param fields lowest-first over a registered ready/valid stream.
module config_params_cast_sequencer #(
  parameter int unsigned MASK_WIDTH = 8,
  parameter int unsigned FIELD_W    = 64,
  parameter int unsigned ID_W       = 8,
  parameter int unsigned TRIG_DEPTH = 4,
  parameter int unsigned FIRST_ONLY = 0
) (
  input logic                           ap_clk,
  input logic                           areset,
  config_params_cast_sequencer_if.slave bus
);
  localparam int unsigned SLOT_W = (MASK_WIDTH > 1) ? $clog2(MASK_WIDTH) : 1;
  localparam int unsigned CNT_W  = $clog2(TRIG_DEPTH) + 1;
  localparam int unsigned PTR_W  = $clog2(TRIG_DEPTH);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e state_q, state_d;

  logic [MASK_WIDTH-1:0]         cast_q, lane_q;
  logic [MASK_WIDTH*ID_W-1:0]    bid_q, lid_q;
  logic [MASK_WIDTH*FIELD_W-1:0] field_q;

  logic [MASK_WIDTH-1:0] fifo_q [TRIG_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [15:0]           drop_q;

  logic [MASK_WIDTH-1:0] match_raw, match, e_q, e_d, e_rest;
  logic                  accept, push, pop, cfg_ready, trig_ready;

  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [FIELD_W-1:0]    out_field_q, out_field_d;
  logic [SLOT_W-1:0]     out_idx_q, out_idx_d, slot_d;
  logic [MASK_WIDTH-1:0] out_kv_q, out_kv_d;

  function automatic logic [SLOT_W-1:0] low_idx(input logic [MASK_WIDTH-1:0] v);
    low_idx = '0;
    for (int i = int'(MASK_WIDTH) - 1; i >= 0; i--) begin
      if (v[i]) low_idx = SLOT_W'(i);
    end
  endfunction

  assign cfg_ready  = (count_q == '0) && (state_q == StIdle);
  assign trig_ready = (count_q < CNT_W'(TRIG_DEPTH));
  assign accept     = bus.trig_valid && trig_ready;

  always_comb begin
    match_raw = '0;
    for (int i = 0; i < int'(MASK_WIDTH); i++) begin
      match_raw[i] = (cast_q[i] | lane_q[i]) &
                     (bus.trig_bundle_id == bid_q[i*ID_W +: ID_W]) &
                     (bus.trig_lane_id == lid_q[i*ID_W +: ID_W]);
    end
  end

  // Two's-complement trick isolates the lowest set bit.
  assign match = (FIRST_ONLY != 0) ? (match_raw & (~match_raw + MASK_WIDTH'(1))) : match_raw;
  assign push  = accept && (match != '0);

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    pop     = 1'b0;
    e_rest  = e_q & (e_q - MASK_WIDTH'(1));
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          e_d     = fifo_q[rd_ptr_q];
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          if (e_rest != '0) begin
            e_d = e_rest;
          end else if (count_q != '0) begin
            pop = 1'b1;
            e_d = fifo_q[rd_ptr_q];
          end else begin
            e_d     = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Output registers are computed from the next emit mask so they update with the state.
  always_comb begin
    out_valid_d = (state_d == StEmit);
    slot_d      = low_idx(e_d);
    out_idx_d   = out_valid_d ? slot_d : '0;
    out_field_d = out_valid_d ? field_q[slot_d*FIELD_W +: FIELD_W] : '0;
    out_last_d  = out_valid_d && ((e_d & (e_d - MASK_WIDTH'(1))) == '0);
    out_kv_d    = '0;
    for (int i = 0; i < int'(MASK_WIDTH); i++) begin
      out_kv_d[i] = out_valid_d && (i >= int'(slot_d));
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      cast_q      <= '0;
      lane_q      <= '0;
      bid_q       <= '0;
      lid_q       <= '0;
      field_q     <= '0;
      state_q     <= StIdle;
      e_q         <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      drop_q      <= '0;
      out_valid_q <= 1'b0;
      out_field_q <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_kv_q    <= '0;
    end else begin
      if (bus.cfg_load && cfg_ready) begin
        cast_q  <= bus.cfg_cast_mask;
        lane_q  <= bus.cfg_lane_mask;
        bid_q   <= bus.cfg_bundle_id;
        lid_q   <= bus.cfg_lane_id;
        field_q <= bus.cfg_param_field;
      end
      state_q <= state_d;
      e_q     <= e_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (accept && (match == '0) && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      out_valid_q <= out_valid_d;
      out_field_q <= out_field_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_kv_q    <= out_kv_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (push) fifo_q[wr_ptr_q] <= match;
  end

  assign bus.cfg_ready        = cfg_ready;
  assign bus.trig_ready       = trig_ready;
  assign bus.out_valid        = out_valid_q;
  assign bus.out_param_field  = out_field_q;
  assign bus.out_slot_idx     = out_idx_q;
  assign bus.out_last         = out_last_q;
  assign bus.out_kernel_valid = out_kv_q;
  assign bus.pending_count    = count_q;
  assign bus.drop_count       = drop_q;
endmodule

// File: tb/tb_config_params_cast_sequencer.sv
// Directed bench for the parameter-cast sequencer: one instance emitting all matches and
// one emitting only the lowest match per trigger.
module tb_config_params_cast_sequencer;
  logic ap_clk = 1'b0;
  logic areset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 ap_clk = ~ap_clk;

  config_params_cast_sequencer_if #(.MASK_WIDTH(8), .FIELD_W(64), .ID_W(8), .TRIG_DEPTH(4)) bus ();
  config_params_cast_sequencer_if #(.MASK_WIDTH(8), .FIELD_W(64), .ID_W(8), .TRIG_DEPTH(4)) bus1 ();

  config_params_cast_sequencer #(.FIRST_ONLY(0)) dut (
    .ap_clk (ap_clk),
    .areset (areset),
    .bus    (bus)
  );

  config_params_cast_sequencer #(.FIRST_ONLY(1)) dut_first (
    .ap_clk (ap_clk),
    .areset (areset),
    .bus    (bus1)
  );

  assign bus1.cfg_load        = bus.cfg_load;
  assign bus1.cfg_cast_mask   = bus.cfg_cast_mask;
  assign bus1.cfg_lane_mask   = bus.cfg_lane_mask;
  assign bus1.cfg_bundle_id   = bus.cfg_bundle_id;
  assign bus1.cfg_lane_id     = bus.cfg_lane_id;
  assign bus1.cfg_param_field = bus.cfg_param_field;
  assign bus1.trig_bundle_id  = bus.trig_bundle_id;
  assign bus1.trig_lane_id    = bus.trig_lane_id;

  function automatic logic [63:0] fld(input int i);
    return {32'hF1E1_D000 | 32'(i), 32'h0000_1000 * 32'(i + 1)};
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input bit last, input logic [7:0] kv);
    check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, ".idx"}, 64'(bus.out_slot_idx), 64'(idx));
    check({tag, ".last"}, 64'(bus.out_last), 64'(last));
    check({tag, ".kv"}, 64'(bus.out_kernel_valid), 64'(kv));
    check({tag, ".field"}, bus.out_param_field, fld(idx));
  endtask

  // mode 0: all ids 3/1; mode 1: bundle id = slot/2, lane 1; mode 2: junk.
  task automatic drive_cfg(input logic [7:0] cast, input logic [7:0] lane, input int mode);
    for (int i = 0; i < 8; i++) begin
      bus.cfg_bundle_id[i*8 +: 8]     = (mode == 1) ? 8'(i / 2) : ((mode == 0) ? 8'd3 : 8'd0);
      bus.cfg_lane_id[i*8 +: 8]       = (mode == 2) ? 8'd0 : 8'd1;
      bus.cfg_param_field[i*64 +: 64] = (mode == 2) ? 64'hDEAD_BEEF : fld(i);
    end
    bus.cfg_cast_mask = cast;
    bus.cfg_lane_mask = lane;
    bus.cfg_load      = 1'b1;
    tick();
    bus.cfg_load      = 1'b0;
  endtask

  initial begin
    int exp_idx [10];
    exp_idx = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    areset = 1'b1;
    bus.cfg_load = 1'b0;
    bus.cfg_cast_mask = '0;
    bus.cfg_lane_mask = '0;
    bus.cfg_bundle_id = '0;
    bus.cfg_lane_id = '0;
    bus.cfg_param_field = '0;
    bus.trig_valid = 1'b0;
    bus.trig_bundle_id = '0;
    bus.trig_lane_id = '0;
    bus.out_ready = 1'b1;
    bus1.trig_valid = 1'b0;
    bus1.out_ready = 1'b1;
    tick();
    tick();
    areset = 1'b0;

    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.pending", 64'(bus.pending_count), 64'd0);
    check("rst.drop", 64'(bus.drop_count), 64'd0);
    check("rst.cfg_ready", 64'(bus.cfg_ready), 64'd1);
    check("rst.trig_ready", 64'(bus.trig_ready), 64'd1);
    check("rst.field", bus.out_param_field, 64'd0);

    // Three-slot burst with continuous out_ready.
    drive_cfg(8'h0B, 8'h00, 0);
    bus.trig_valid = 1'b1;
    bus.trig_bundle_id = 8'd3;
    bus.trig_lane_id = 8'd1;
    tick();
    bus.trig_valid = 1'b0;
    check("t1.lat_valid", 64'(bus.out_valid), 64'd0);
    check("t1.lat_pending", 64'(bus.pending_count), 64'd1);
    tick();
    check_beat("t1.b0", 0, 1'b0, 8'hFF);
    tick();
    check_beat("t1.b1", 1, 1'b0, 8'hFE);
    tick();
    check_beat("t1.b3", 3, 1'b1, 8'hF8);
    tick();
    check("t1.idle", 64'(bus.out_valid), 64'd0);

    // Lowest-match-only instance.
    bus1.trig_valid = 1'b1;
    tick();
    bus1.trig_valid = 1'b0;
    tick();
    check("t2.valid", 64'(bus1.out_valid), 64'd1);
    check("t2.idx", 64'(bus1.out_slot_idx), 64'd0);
    check("t2.last", 64'(bus1.out_last), 64'd1);
    check("t2.field", bus1.out_param_field, fld(0));
    tick();
    check("t2.idle", 64'(bus1.out_valid), 64'd0);

    // Stall on slot 1, with a config load attempted while busy.
    bus.trig_valid = 1'b1;
    tick();
    bus.trig_valid = 1'b0;
    tick();
    check_beat("t3.b0", 0, 1'b0, 8'hFF);
    tick();
    check_beat("t3.b1", 1, 1'b0, 8'hFE);
    check("t3.cfg_ready", 64'(bus.cfg_ready), 64'd0);
    bus.out_ready = 1'b0;
    drive_cfg(8'h00, 8'h00, 2);
    check_beat("t3.hold0", 1, 1'b0, 8'hFE);
    for (int k = 1; k < 5; k++) begin
      tick();
      check_beat("t3.hold", 1, 1'b0, 8'hFE);
    end
    bus.out_ready = 1'b1;
    tick();
    check_beat("t3.b3", 3, 1'b1, 8'hF8);
    tick();
    check("t3.idle", 64'(bus.out_valid), 64'd0);

    // Fill the queue under backpressure, then drain.
    drive_cfg(8'h0F, 8'hF0, 1);
    bus.out_ready = 1'b0;
    bus.trig_valid = 1'b1;
    bus.trig_lane_id = 8'd1;
    for (int k = 0; k < 5; k++) begin
      bus.trig_bundle_id = 8'(k % 4);
      tick();
    end
    check("t4.pending", 64'(bus.pending_count), 64'd4);
    check("t4.trig_ready", 64'(bus.trig_ready), 64'd0);
    bus.trig_bundle_id = 8'd1;
    tick();
    tick();
    check("t4.pending_hold", 64'(bus.pending_count), 64'd4);
    check("t4.trig_ready_hold", 64'(bus.trig_ready), 64'd0);
    check("t4.head_idx", 64'(bus.out_slot_idx), 64'd0);
    bus.trig_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("t4.drain_valid", 64'(bus.out_valid), 64'd1);
      check("t4.drain_idx", 64'(bus.out_slot_idx), 64'(exp_idx[k]));
      check("t4.drain_last", 64'(bus.out_last), 64'(k % 2));
      tick();
    end
    check("t4.idle", 64'(bus.out_valid), 64'd0);
    check("t4.empty", 64'(bus.pending_count), 64'd0);

    // Zero-match triggers and drop-counter saturation.
    bus.trig_valid = 1'b1;
    bus.trig_bundle_id = 8'd9;
    tick();
    tick();
    tick();
    bus.trig_valid = 1'b0;
    tick();
    check("t5.drop3", 64'(bus.drop_count), 64'd3);
    check("t5.no_valid", 64'(bus.out_valid), 64'd0);
    check("t5.no_push", 64'(bus.pending_count), 64'd0);
    bus.trig_valid = 1'b1;
    repeat (65532) tick();
    check("t5.drop_max", 64'(bus.drop_count), 64'hFFFF);
    tick();
    tick();
    bus.trig_valid = 1'b0;
    check("t5.drop_sat", 64'(bus.drop_count), 64'hFFFF);

    // Reset in the middle of a burst.
    drive_cfg(8'h0B, 8'h00, 0);
    bus.trig_valid = 1'b1;
    bus.trig_bundle_id = 8'd3;
    tick();
    bus.trig_valid = 1'b0;
    tick();
    bus.trig_valid = 1'b1;
    tick();
    bus.trig_valid = 1'b0;
    check_beat("t6.b1", 1, 1'b0, 8'hFE);
    check("t6.pending1", 64'(bus.pending_count), 64'd1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("t6.valid", 64'(bus.out_valid), 64'd0);
    check("t6.pending", 64'(bus.pending_count), 64'd0);
    check("t6.drop", 64'(bus.drop_count), 64'd0);
    check("t6.idx", 64'(bus.out_slot_idx), 64'd0);
    check("t6.cfg_ready", 64'(bus.cfg_ready), 64'd1);
    check("t6.trig_ready", 64'(bus.trig_ready), 64'd1);
    bus.trig_valid = 1'b1;
    tick();
    bus.trig_valid = 1'b0;
    tick();
    check("t6.cfg_cleared_drop", 64'(bus.drop_count), 64'd1);
    check("t6.cfg_cleared_valid", 64'(bus.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
